// File: rtl/histogram_sequencer_if.sv
// rtl/histogram_sequencer_if.sv - Command, sample, RAM-port and dump-stream signals of the histogram sequencer
interface histogram_sequencer_if #(
  parameter int ADDR_W = 7,
  parameter int CNT_W  = 7
);
  logic              cmd_clear;
  logic              cmd_dump;
  logic              s_valid;
  logic [ADDR_W-1:0] s_data;
  logic              s_ready;
  logic [ADDR_W-1:0] ram_addr;
  logic [CNT_W-1:0]  ram_wdata;
  logic              ram_wren;
  logic [CNT_W-1:0]  ram_q;
  logic              o_valid;
  logic [ADDR_W-1:0] o_bin;
  logic [CNT_W-1:0]  o_count;
  logic              o_last;
  logic              o_ready;
  logic              busy;
  logic              done;
  logic              sat_err;

  modport slave (
    input  cmd_clear, cmd_dump, s_valid, s_data, ram_q, o_ready,
    output s_ready, ram_addr, ram_wdata, ram_wren, o_valid, o_bin, o_count, o_last,
           busy, done, sat_err
  );

  modport master (
    output cmd_clear, cmd_dump, s_valid, s_data, ram_q, o_ready,
    input  s_ready, ram_addr, ram_wdata, ram_wren, o_valid, o_bin, o_count, o_last,
           busy, done, sat_err
  );
endinterface

// File: rtl/histogram_sequencer.sv
// rtl/histogram_sequencer.sv - Clear / accumulate / dump controller for a single-port histogram RAM
module histogram_sequencer #(
  parameter int BINS        = 128,
  parameter int ADDR_W      = $clog2(BINS),
  parameter int CNT_W       = 7,
  parameter bit CLR_ON_DUMP = 1'b0
) (
  input logic                  CLK,
  input logic                  RST,
  histogram_sequencer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, CLEAR, ACC_WR, DUMP_RD, DUMP_CAP, DUMP_OUT} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(BINS - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  state_t            state, state_next;
  logic [ADDR_W-1:0] idx, idx_next;
  logic [ADDR_W-1:0] bin, bin_next;
  logic [CNT_W-1:0]  count, count_next;
  logic              sat, sat_next;
  logic              done_r, done_next;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  wdata;
  logic              wren;
  logic              valid;
  logic              ready;
  logic              in_range;

  // Out-of-range bins only exist when BINS does not fill the address space.
  generate
    if (BINS < (2 ** ADDR_W)) begin : g_range
      assign in_range = {1'b0, bus.s_data} < (ADDR_W + 1)'(BINS);
    end else begin : g_full
      assign in_range = 1'b1;
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= CLEAR;
      idx    <= '0;
      bin    <= '0;
      count  <= '0;
      sat    <= 1'b0;
      done_r <= 1'b0;
    end else begin
      state  <= state_next;
      idx    <= idx_next;
      bin    <= bin_next;
      count  <= count_next;
      sat    <= sat_next;
      done_r <= done_next;
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    bin_next   = bin;
    count_next = count;
    sat_next   = sat;
    done_next  = 1'b0;
    addr       = '0;
    wdata      = '0;
    wren       = 1'b0;
    valid      = 1'b0;
    ready      = 1'b0;
    case (state)
      IDLE: begin
        ready = !bus.cmd_clear && !bus.cmd_dump;
        if (bus.cmd_clear) begin
          state_next = CLEAR;
          idx_next   = '0;
        end else if (bus.cmd_dump) begin
          state_next = DUMP_RD;
          idx_next   = '0;
        end else if (bus.s_valid) begin
          if (in_range) begin
            addr       = bus.s_data;
            bin_next   = bus.s_data;
            state_next = ACC_WR;
          end else begin
            sat_next = 1'b1;
          end
        end
      end
      CLEAR: begin
        addr = idx;
        wren = 1'b1;
        if (idx == LAST_IDX) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end else begin
          idx_next = idx + ADDR_W'(1);
        end
      end
      ACC_WR: begin
        addr       = bin;
        wren       = 1'b1;
        state_next = IDLE;
        // A full bin is rewritten unchanged so the counter never wraps.
        if (bus.ram_q == CNT_MAX) begin
          wdata    = bus.ram_q;
          sat_next = 1'b1;
        end else begin
          wdata = bus.ram_q + CNT_W'(1);
        end
      end
      DUMP_RD: begin
        addr       = idx;
        state_next = DUMP_CAP;
      end
      DUMP_CAP: begin
        addr       = idx;
        wren       = CLR_ON_DUMP;
        count_next = bus.ram_q;
        state_next = DUMP_OUT;
      end
      DUMP_OUT: begin
        valid = 1'b1;
        if (bus.o_ready) begin
          if (idx == LAST_IDX) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            idx_next   = idx + ADDR_W'(1);
            state_next = DUMP_RD;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Reset holds every output low even before the first clock edge sees it.
  assign bus.s_ready   = !RST && ready;
  assign bus.ram_addr  = RST ? '0 : addr;
  assign bus.ram_wdata = RST ? '0 : wdata;
  assign bus.ram_wren  = !RST && wren;
  assign bus.o_valid   = !RST && valid;
  assign bus.o_bin     = (!RST && valid) ? idx : '0;
  assign bus.o_count   = RST ? '0 : count;
  assign bus.o_last    = !RST && valid && (idx == LAST_IDX);
  assign bus.busy      = !RST && (state != IDLE);
  assign bus.done      = !RST && done_r;
  assign bus.sat_err   = !RST && sat;
endmodule

// File: tb/tb_histogram_sequencer.sv
// tb/tb_histogram_sequencer.sv - Randomized bench for histogram_sequencer against a bin-count array model
module tb_histogram_sequencer;
  localparam int BINS   = 128;
  localparam int ADDR_W = 7;
  localparam int CNT_W  = 7;
  localparam int MAXC   = 127;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  histogram_sequencer_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus0 ();
  histogram_sequencer_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus1 ();

  histogram_sequencer #(.BINS(BINS), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .CLR_ON_DUMP(1'b0)) u_keep (
    .CLK(CLK), .RST(RST), .bus(bus0)
  );
  histogram_sequencer #(.BINS(BINS), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .CLR_ON_DUMP(1'b1)) u_clr (
    .CLK(CLK), .RST(RST), .bus(bus1)
  );

  logic [CNT_W-1:0] mem0 [BINS];
  logic [CNT_W-1:0] mem1 [BINS];

  always @(posedge CLK) begin
    if (bus0.ram_wren) mem0[bus0.ram_addr] <= bus0.ram_wdata;
    bus0.ram_q <= mem0[bus0.ram_addr];
  end

  always @(posedge CLK) begin
    if (bus1.ram_wren) mem1[bus1.ram_addr] <= bus1.ram_wdata;
    bus1.ram_q <= mem1[bus1.ram_addr];
  end

  // Model: per-instance bin counts and expected sticky saturation flag.
  int hist [2][BINS];
  bit sat_exp [2];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic clr, input logic dmp, input logic sv, input int sd, input logic rdy);
    bus0.cmd_clear = clr;  bus1.cmd_clear = clr;
    bus0.cmd_dump  = dmp;  bus1.cmd_dump  = dmp;
    bus0.s_valid   = sv;   bus1.s_valid   = sv;
    bus0.s_data    = ADDR_W'(sd);
    bus1.s_data    = ADDR_W'(sd);
    bus0.o_ready   = rdy;  bus1.o_ready   = rdy;
  endtask

  task automatic peek(input int k, output logic v, output logic [31:0] b, output logic [31:0] c,
                      output logic l);
    if (k == 0) begin
      v = bus0.o_valid; b = 32'(bus0.o_bin); c = 32'(bus0.o_count); l = bus0.o_last;
    end else begin
      v = bus1.o_valid; b = 32'(bus1.o_bin); c = 32'(bus1.o_count); l = bus1.o_last;
    end
  endtask

  function automatic void model_sample(input int b);
    for (int k = 0; k < 2; k++) begin
      if (b >= BINS) sat_exp[k] = 1'b1;
      else if (hist[k][b] == MAXC) sat_exp[k] = 1'b1;
      else hist[k][b]++;
    end
  endfunction

  // Starts in the slot showing the first clear cycle; ends one idle cycle after done.
  task automatic run_clear(input bit poke_dump);
    for (int c = 0; c < BINS; c++) begin
      set_in(1'b0, poke_dump && (c == 50), 1'b0, 0, 1'b0);
      #1;
      check("clr_busy", {bus0.busy, bus1.busy}, 3);
      check("clr_addr0", bus0.ram_wren ? 32'(bus0.ram_addr) : 32'd999, c);
      check("clr_addr1", bus1.ram_wren ? 32'(bus1.ram_addr) : 32'd999, c);
      @(negedge CLK);
    end
    set_in(1'b0, 1'b0, 1'b0, 0, 1'b0);
    #1;
    check("clr_done", {bus0.done, bus1.done}, 3);
    check("clr_idle", {bus0.busy, bus1.busy}, 0);
    check("clr_s_ready", {bus0.s_ready, bus1.s_ready}, 3);
    @(negedge CLK);
    #1;
    check("clr_done_pulse", {bus0.done, bus1.done}, 0);
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < BINS; i++) hist[k][i] = 0;
  endtask

  task automatic stream(input int smp[$], input bit gaps);
    int  i = 0;
    int  budget = 0;
    bit  prev = 1'b0;
    bit  v;
    @(negedge CLK);
    while (i < smp.size() && budget < 8 * smp.size() + 20) begin
      v = !gaps || ($urandom_range(0, 3) != 0);
      set_in(1'b0, 1'b0, v, smp[i], 1'b0);
      #1;
      check("s_ready", {bus0.s_ready, bus1.s_ready}, prev ? 0 : 3);
      prev = v && bus0.s_ready;
      if (prev) begin
        model_sample(smp[i]);
        i++;
      end
      @(negedge CLK);
      budget++;
    end
    check("stream_accepted", i, smp.size());
    set_in(1'b0, 1'b0, 1'b0, 0, 1'b0);
    @(negedge CLK);
    #1;
    check("sat_err0", bus0.sat_err, sat_exp[0]);
    check("sat_err1", bus1.sat_err, sat_exp[1]);
  endtask

  task automatic do_dump(input bit stall, input int abort_at);
    int   nb [2];
    int   stalls = 0;
    int   budget = 0;
    logic rdy;
    logic v, l;
    logic [31:0] b, c;
    nb = '{0, 0};
    @(negedge CLK);
    set_in(1'b0, 1'b1, 1'b0, 0, 1'b0);
    #1;
    check("dump_cmd_s_ready", {bus0.s_ready, bus1.s_ready}, 0);
    @(negedge CLK);
    while ((nb[0] < BINS || nb[1] < BINS) && budget < 4000) begin
      rdy = !(stall && nb[0] == 0 && stalls < 10) && ($urandom_range(0, 3) != 0);
      set_in(1'b0, 1'b0, 1'b0, 0, rdy);
      #1;
      if (abort_at >= 0 && bus0.o_valid && nb[0] == abort_at) begin
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        #1;
        check("abort_o_valid", {bus0.o_valid, bus1.o_valid}, 0);
        run_clear(1'b1);
        sat_exp = '{1'b0, 1'b0};
        check("abort_sat_cleared", {bus0.sat_err, bus1.sat_err}, 0);
        return;
      end
      for (int k = 0; k < 2; k++) begin
        peek(k, v, b, c, l);
        if (v && nb[k] < BINS) begin
          check($sformatf("dump%0d_bin", k), b, nb[k]);
          check($sformatf("dump%0d_count[%0d]", k, nb[k]), c, hist[k][nb[k]]);
          check($sformatf("dump%0d_last[%0d]", k, nb[k]), l, nb[k] == BINS - 1);
          if (rdy) nb[k]++;
          else if (k == 0 && nb[0] == 0) stalls++;
        end
      end
      @(negedge CLK);
      budget++;
    end
    check("dump0_handshakes", nb[0], BINS);
    check("dump1_handshakes", nb[1], BINS);
    if (stall) check("dump_stall_cycles", stalls, 10);
    set_in(1'b0, 1'b0, 1'b0, 0, 1'b0);
    #1;
    check("dump_done", {bus0.done, bus1.done}, 3);
    check("dump_idle", {bus0.busy, bus1.busy}, 0);
    check("dump_o_valid_off", {bus0.o_valid, bus1.o_valid}, 0);
    for (int i = 0; i < BINS; i++) hist[1][i] = 0;
    @(negedge CLK);
    #1;
    check("dump_done_pulse", {bus0.done, bus1.done}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int q[$];
    set_in(1'b0, 1'b0, 1'b0, 0, 1'b0);
    sat_exp = '{1'b0, 1'b0};
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    #1;
    check("rst_busy", {bus0.busy, bus1.busy}, 0);
    check("rst_wren", {bus0.ram_wren, bus1.ram_wren}, 0);
    check("rst_o_valid", {bus0.o_valid, bus1.o_valid}, 0);
    check("rst_sat", {bus0.sat_err, bus1.sat_err}, 0);
    check("rst_done", {bus0.done, bus1.done}, 0);
    check("rst_s_ready", {bus0.s_ready, bus1.s_ready}, 0);
    RST = 1'b0;
    run_clear(1'b0);

    q = '{5, 5, 5, 9};
    stream(q, 1'b0);
    do_dump(1'b1, -1);

    q.delete();
    for (int i = 0; i < 60; i++)
      q.push_back($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, BINS - 1));
    stream(q, 1'b1);
    do_dump(1'b0, -1);

    q.delete();
    repeat (130) q.push_back(3);
    stream(q, 1'b1);
    do_dump(1'b0, -1);

    @(negedge CLK);
    set_in(1'b1, 1'b0, 1'b0, 0, 1'b0);
    #1;
    check("cmd_clear_s_ready", {bus0.s_ready, bus1.s_ready}, 0);
    @(negedge CLK);
    set_in(1'b0, 1'b0, 1'b0, 0, 1'b0);
    run_clear(1'b0);
    check("sat_sticky", {bus0.sat_err, bus1.sat_err}, 3);

    q = '{7, 7, 7, 7};
    stream(q, 1'b1);
    do_dump(1'b0, -1);
    do_dump(1'b0, -1);

    q.delete();
    for (int i = 0; i < 40; i++) q.push_back($urandom_range(0, BINS - 1));
    stream(q, 1'b1);
    do_dump(1'b0, 40);

    @(negedge CLK);
    set_in(1'b1, 1'b1, 1'b1, 12, 1'b0);
    #1;
    check("triple_cmd_s_ready", {bus0.s_ready, bus1.s_ready}, 0);
    @(negedge CLK);
    set_in(1'b0, 1'b0, 1'b0, 0, 1'b0);
    run_clear(1'b0);
    do_dump(1'b0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
